// File: rtl/song_player_pkg.sv
// song_player_pkg: shared types and default field widths for the song player.
// A note entry is {half_period, duration}; duration 0 marks the end of a song,
// half_period 0 marks a rest.
package song_player_pkg;

  localparam int unsigned NOTE_HALF_W = 16;
  localparam int unsigned NOTE_DUR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY
  } state_e;

  typedef struct packed {
    logic [NOTE_HALF_W-1:0] half_period;
    logic [NOTE_DUR_W-1:0]  duration;
  } note_t;

endpackage

// File: rtl/song_player_tone_gen.sv
// song_player_tone_gen: square-wave generator. While en is high the half
// counter runs 0..half_period-1 and the tone flips on each wrap. Dropping en
// clears the counter and the tone, so each note starts low from a fresh count.
// The output is forced low when disabled or when half_period is 0 (a rest).
module song_player_tone_gen
  import song_player_pkg::*;
#(
  parameter int unsigned HALF_W = NOTE_HALF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [HALF_W-1:0] half_period,
  output logic              audio
);

  localparam logic [HALF_W-1:0] HALF_ONE = HALF_W'(1);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              tone_q, tone_d;

  // Next-state logic for the half-period counter and the tone level.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (!en || half_period == '0) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == half_period - HALF_ONE) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + HALF_ONE;
    end
  end

  // Counter and tone registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample the same edge values.
    if (!rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign audio = tone_q & en & (half_period != '0);

endmodule

// File: rtl/song_player.sv
// song_player: reads note entries from address 0, plays each one as a square
// wave for duration*TICK_DIV cycles and stops at an end marker (duration 0).
// Build option SONG_PLAYER_LOOP_EN: after the end marker, pulse done and
// restart from address 0 (busy stays high) until stop; otherwise return to IDLE.
module song_player
  import song_player_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned HALF_W   = NOTE_HALF_W,
  parameter int unsigned DUR_W    = NOTE_DUR_W,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [HALF_W+DUR_W-1:0] mem_data,
  output logic                    audio,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned       TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DUR_W-1:0]  remain_q, remain_d;
  logic [HALF_W-1:0] half_q, half_d;

  logic [HALF_W-1:0] in_half;
  logic [DUR_W-1:0]  in_dur;
  logic              tone_en;

  assign in_half = mem_data[HALF_W+DUR_W-1:DUR_W];
  assign in_dur  = mem_data[DUR_W-1:0];

  // Sequencer: fetch, load and play notes; stop overrides everything.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    done_d   = 1'b0;
    tick_d   = tick_q;
    remain_d = remain_q;
    half_d   = half_q;
    if (stop) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FETCH;
            addr_d  = '0;
            rd_d    = 1'b1;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          if (in_dur == '0) begin
            done_d = 1'b1;
            addr_d = '0;
`ifdef SONG_PLAYER_LOOP_EN
            state_d = ST_FETCH;
            rd_d    = 1'b1;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            half_d   = in_half;
            remain_d = in_dur;
            tick_d   = '0;
            state_d  = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (remain_q == DUR_ONE) begin
              state_d = ST_FETCH;
              addr_d  = addr_q + ADDR_ONE;
              rd_d    = 1'b1;
            end else begin
              remain_d = remain_q - DUR_ONE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tick_q   <= '0;
      remain_q <= '0;
      half_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tick_q   <= tick_d;
      remain_q <= remain_d;
      half_q   <= half_d;
    end
  end

  assign tone_en = (state_q == ST_PLAY);

  song_player_tone_gen #(
    .HALF_W (HALF_W)
  ) u_tone_gen (
    .clk         (clk),
    .rst         (rst),
    .en          (tone_en),
    .half_period (half_q),
    .audio       (audio)
  );

  assign mem_rd   = rd_q;
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_song_player.sv
// tb_song_player: scoreboard bench for song_player. A note-level model turns
// the song memory, the start cycle and the stop cycle into expected event
// lists (read strobes, done pulses, audio edges, busy edges); a monitor pops
// and compares them whenever the DUT shows one of those events.
module tb_song_player;
  import song_player_pkg::*;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TD     = 4;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic                            clk = 1'b0;
  logic                            rst, start, stop;
  logic                            mem_rd, audio, busy, done;
  logic [ADDR_W-1:0]               mem_addr;
  logic [NOTE_HALF_W+NOTE_DUR_W-1:0] mem_data;

  note_t mem [DEPTH];
  ev_t   rd_q[$], done_q[$], aud_q[$], busy_q[$];
  int    cyc = 0;
  int    n_cmp = 0, n_err = 0;
  bit    mon_en = 1'b0;
  logic  prev_audio = 1'b0, prev_busy = 1'b0;

  song_player #(
    .ADDR_W   (ADDR_W),
    .HALF_W   (NOTE_HALF_W),
    .DUR_W    (NOTE_DUR_W),
    .TICK_DIV (TD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .audio    (audio),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Note memory: data valid the cycle after the read strobe.
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  function automatic note_t mk(input int hp, input int dur);
    note_t n;
    n.half_period = NOTE_HALF_W'(hp);
    n.duration    = NOTE_DUR_W'(dur);
    return n;
  endfunction

  // Note-level reference: l = cycle of the first read strobe, s = first cycle
  // forced idle by stop, hold = start stays high (restart after a marker).
  task automatic gen_expected(input int l, input int s, input bit hold);
    int t, addr, hp, dur, p0, len, steps;
    bit lvl, stopped;
    t = l; addr = 0; lvl = 1'b0; stopped = 1'b0; steps = 0;
    busy_q.push_back('{cyc: l, val: 1});
    while (steps < 1000) begin
      steps++;
      if (t >= s) begin stopped = 1'b1; break; end
      rd_q.push_back('{cyc: t, val: addr});
      hp  = int'(mem[addr].half_period);
      dur = int'(mem[addr].duration);
      if (dur == 0) begin
        if (t + 2 >= s) begin stopped = 1'b1; break; end
        done_q.push_back('{cyc: t + 2, val: 1});
`ifdef SONG_PLAYER_LOOP_EN
        addr = 0;
        t    = t + 2;
        continue;
`else
        busy_q.push_back('{cyc: t + 2, val: 0});
        if (!hold || t + 3 >= s) return;
        busy_q.push_back('{cyc: t + 3, val: 1});
        addr = 0;
        t    = t + 3;
        continue;
`endif
      end
      p0  = t + 2;
      len = dur * TD;
      if (hp != 0) begin
        for (int c = p0 + hp; c < p0 + len; c += hp) begin
          if (c >= s) begin stopped = 1'b1; break; end
          lvl = ~lvl;
          aud_q.push_back('{cyc: c, val: int'(lvl)});
        end
      end
      if (stopped) break;
      if (p0 + len >= s) begin stopped = 1'b1; break; end
      if (lvl) begin
        aud_q.push_back('{cyc: p0 + len, val: 0});
        lvl = 1'b0;
      end
      addr = (addr + 1) % DEPTH;
      t    = p0 + len;
    end
    if (stopped) begin
      busy_q.push_back('{cyc: s, val: 0});
      if (lvl) aud_q.push_back('{cyc: s, val: 0});
    end
  endtask

  // Monitor: pop and compare on every DUT-visible event.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (mem_rd) begin
        if (rd_q.size() == 0) unexpected("rd");
        else begin
          e = rd_q.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_addr", int'(mem_addr), e.val);
        end
      end
      if (done) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          e = done_q.pop_front();
          check("done_cycle", cyc, e.cyc);
        end
      end
      if (audio !== prev_audio) begin
        if (aud_q.size() == 0) unexpected("audio_edge");
        else begin
          e = aud_q.pop_front();
          check("audio_cycle", cyc, e.cyc);
          check("audio_level", int'(audio), e.val);
        end
      end
      if (busy !== prev_busy) begin
        if (busy_q.size() == 0) unexpected("busy_edge");
        else begin
          e = busy_q.pop_front();
          check("busy_cycle", cyc, e.cyc);
          check("busy_level", int'(busy), e.val);
        end
      end
    end
    prev_audio = audio;
    prev_busy  = busy;
  end

  // Start a song, stop it stop_off cycles after the first read, hold stop
  // (and start, if held) for stop_len cycles, then confirm nothing is left over.
  task automatic run_song(input int stop_off, input bit hold, input int stop_len, input string tag);
    int l, s;
    @(negedge clk);
    l = cyc + 1;
    s = l + stop_off;
    gen_expected(l, s, hold);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    while (cyc + 1 < s) @(negedge clk);
    stop = 1'b1;
    repeat (stop_len) @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_rd_left"},    rd_q.size(),   0);
    check({tag, "_done_left"},  done_q.size(), 0);
    check({tag, "_audio_left"}, aud_q.size(),  0);
    check({tag, "_busy_left"},  busy_q.size(), 0);
    check({tag, "_idle"},       int'(busy),    0);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(v, 0);
  endtask

  initial begin
    int k;
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b1;
    fill(0);
    #2 rst = 1'b0;
    #1;
    check("reset_audio", int'(audio),    0);
    check("reset_busy",  int'(busy),     0);
    check("reset_done",  int'(done),     0);
    check("reset_rd",    int'(mem_rd),   0);
    check("reset_addr",  int'(mem_addr), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Basic note then end marker.
    fill(0);
    mem[0] = mk(3, 2);
    mem[1] = mk(7, 0);
    run_song(60, 1'b0, 1, "basic");

    // Rest followed by a tone.
    fill(0);
    mem[0] = mk(0, 3);
    mem[1] = mk(2, 1);
    mem[2] = mk(0, 0);
    run_song(60, 1'b0, 1, "rest");

    // Stop 5 cycles into PLAY with start held; no restart while stop held.
    fill(0);
    mem[0] = mk(2, 4);
    mem[1] = mk(1, 2);
    run_song(2 + 5, 1'b1, 5, "stop");

    // No marker anywhere: address wraps 3 -> 0 and playback continues.
    mem[0] = mk(1, 1);
    mem[1] = mk(2, 1);
    mem[2] = mk(0, 1);
    mem[3] = mk(3, 2);
    run_song(70, 1'b0, 2, "wrap");

    // Marker at address 2 (loops back to 0 in the looping build).
    fill(0);
    mem[0] = mk(1, 1);
    mem[1] = mk(2, 1);
    mem[2] = mk(5, 0);
    run_song(40, 1'b0, 1, "marker2");

    // Randomized songs, stop points and start handling.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] = mk($urandom_range(0, 5), ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3));
      run_song($urandom_range(1, 90), 1'($urandom_range(0, 1)), $urandom_range(1, 4), "rand");
    end

    // Asynchronous reset in the middle of a sounding note.
    fill(0);
    mem[0] = mk(2, 4);
    @(negedge clk);
    gen_expected(cyc + 1, cyc + 1000, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (audio !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("rst_setup_audio", int'(audio), 1);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_mid_audio", int'(audio),    0);
    check("rst_mid_busy",  int'(busy),     0);
    check("rst_mid_addr",  int'(mem_addr), 0);
    check("rst_mid_rd",    int'(mem_rd),   0);
    rd_q.delete();
    done_q.delete();
    aud_q.delete();
    busy_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Recovery after reset.
    fill(0);
    mem[0] = mk(3, 2);
    run_song(60, 1'b0, 1, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
